// File: rtl/cp0_exception_ctrl.sv
// cp0_exception_ctrl
//   Coprocessor-0 exception controller. Holds Status(12), Cause(13) and EPC(14),
//   accepts synchronous exceptions, external interrupts and eret from decode,
//   and issues a registered one-cycle PC redirect followed by a multi-cycle
//   pipeline flush.
// Ports
//   clock, reset          : system clock, synchronous active-high reset
//   exc_break/exc_syscall/exc_overflow/exc_reserved : exception events
//   eret                  : return from exception
//   mtc0/mfc0, cp0_sel    : CP0 write/read strobes and register number
//   wdata                 : mtc0 write data
//   pc_plus_4             : value saved to EPC on exception/interrupt
//   pipe_stall            : no event accepted while high
//   irq                   : asynchronous level interrupt requests
//   rdata                 : mfc0 read data (combinational, all-ones when idle)
//   redirect_valid/pc     : one-cycle redirect strobe and target
//   flush, busy           : flush window / FSM not idle
//   status_q/cause_q/epc_q: current register values
module cp0_exception_ctrl #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_IRQ      = 6,
  parameter logic [DATA_WIDTH-1:0] EXC_VECTOR = 32'h0000F000,
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exc_break,
  input  logic                  exc_syscall,
  input  logic                  exc_overflow,
  input  logic                  exc_reserved,
  input  logic                  eret,
  input  logic                  mtc0,
  input  logic                  mfc0,
  input  logic [4:0]            cp0_sel,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] pc_plus_4,
  input  logic                  pipe_stall,
  input  logic [NUM_IRQ-1:0]    irq,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  flush,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] status_q,
  output logic [DATA_WIDTH-1:0] cause_q,
  output logic [DATA_WIDTH-1:0] epc_q
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;
  localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [4:0] EC_INT = 5'd0;
  localparam logic [4:0] EC_SYS = 5'd8;
  localparam logic [4:0] EC_BP  = 5'd9;
  localparam logic [4:0] EC_RI  = 5'd10;
  localparam logic [4:0] EC_OV  = 5'd12;

  logic [NUM_IRQ-1:0]    irq_s1, irq_s2;
  logic [DATA_WIDTH-1:0] status_r, epc_r;
  logic [4:0]            exc_code_r;
  logic [1:0]            sw_ip_r;
  logic [0:0]            state_r;
  logic [CW-1:0]         cnt_r;

  logic                  int_req, any_exc, idle_go;
  logic                  take_exc, take_eret, do_mtc0;
  logic [4:0]            exc_code_nxt;

  // Cause is assembled, not stored whole: hardware IP follows the synchronised
  // irq lines every cycle, and the two software IP bits are ORed onto [9:8]
  // (they share positions with irq[1:0]).
  always_comb begin
    cause_q      = '0;
    cause_q[6:2] = exc_code_r;
    for (int i = 0; i < int'(NUM_IRQ); i++) cause_q[8+i] = irq_s2[i];
    cause_q[9:8] = cause_q[9:8] | sw_ip_r;
  end

  assign status_q = status_r;
  assign epc_q    = epc_r;

  assign int_req = status_r[0] & (|(cause_q[15:8] & status_r[15:8]));
  assign any_exc = exc_reserved | exc_overflow | exc_syscall | exc_break | int_req;
  assign idle_go = (state_r == ST_IDLE) & ~pipe_stall;

  assign take_exc  = idle_go & any_exc;
  assign take_eret = idle_go & ~any_exc & eret;
  assign do_mtc0   = idle_go & ~any_exc & ~eret & mtc0;

  always_comb begin
    exc_code_nxt = EC_INT;
    if      (exc_reserved) exc_code_nxt = EC_RI;
    else if (exc_overflow) exc_code_nxt = EC_OV;
    else if (exc_syscall)  exc_code_nxt = EC_SYS;
    else if (exc_break)    exc_code_nxt = EC_BP;
  end

  // mfc0 reads pre-edge register values, so a same-cycle mtc0 is not visible.
  always_comb begin
    rdata = '1;
    if (mfc0) begin
      case (cp0_sel)
        5'd12:   rdata = status_r;
        5'd13:   rdata = cause_q;
        5'd14:   rdata = epc_r;
        default: rdata = '1;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      irq_s1 <= '0;
      irq_s2 <= '0;
    end else begin
      irq_s1 <= irq;
      irq_s2 <= irq_s1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      status_r   <= '0;
      epc_r      <= '0;
      exc_code_r <= '0;
      sw_ip_r    <= '0;
    end else if (take_exc) begin
      status_r[0] <= 1'b0;
      exc_code_r  <= exc_code_nxt;
      epc_r       <= pc_plus_4;
    end else if (take_eret) begin
      status_r[0] <= 1'b1;
    end else if (do_mtc0) begin
      case (cp0_sel)
        5'd12:   status_r <= wdata;
        5'd13:   sw_ip_r  <= wdata[9:8];
        5'd14:   epc_r    <= wdata;
        default: ;
      endcase
    end
  end

  // Redirect target sits at all-ones except during the strobe cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '1;
    end else begin
      redirect_valid <= take_exc | take_eret;
      if (take_exc)       redirect_pc <= EXC_VECTOR;
      else if (take_eret) redirect_pc <= epc_r;
      else                redirect_pc <= '1;
    end
  end

  // Counter is loaded with FLUSH_CYCLES-1 so FLUSH lasts exactly FLUSH_CYCLES.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (take_exc | take_eret) begin
            state_r <= ST_FLUSH;
            cnt_r   <= CW'(FLUSH_CYCLES - 1);
          end
        end
        default: begin
          if (cnt_r == '0) state_r <= ST_IDLE;
          else             cnt_r   <= cnt_r - 1'b1;
        end
      endcase
    end
  end

  assign flush = (state_r == ST_FLUSH);
  assign busy  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
module tb_cp0_exception_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic        exc_break, exc_syscall, exc_overflow, exc_reserved, eret;
  logic        mtc0, mfc0, pipe_stall;
  logic [4:0]  cp0_sel;
  logic [31:0] wdata, pc_plus_4;
  logic [5:0]  irq;
  logic [31:0] rdata, redirect_pc, status_q, cause_q, epc_q;
  logic        redirect_valid, flush, busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        mon_en = 1'b0;
  logic [31:0] exp_q[$];

  cp0_exception_ctrl dut (
    .clock(clock), .reset(reset),
    .exc_break(exc_break), .exc_syscall(exc_syscall),
    .exc_overflow(exc_overflow), .exc_reserved(exc_reserved),
    .eret(eret), .mtc0(mtc0), .mfc0(mfc0), .cp0_sel(cp0_sel),
    .wdata(wdata), .pc_plus_4(pc_plus_4), .pipe_stall(pipe_stall), .irq(irq),
    .rdata(rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .busy(busy),
    .status_q(status_q), .cause_q(cause_q), .epc_q(epc_q)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [4:0] sel, input logic [31:0] exp, input string tag);
    mfc0 = 1'b1;
    cp0_sel = sel;
    #1;
    chk(tag, rdata, exp);
    mfc0 = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && busy; i++) step();
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  // Every redirect must match the oldest expected target; between strobes the
  // target must read all-ones.
  always @(negedge clock) begin
    if (mon_en) begin
      if (redirect_valid) begin
        chk("redir_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) chk("redir_pc", redirect_pc, exp_q.pop_front());
      end else begin
        chk("redir_pc_idle", redirect_pc, 32'hFFFF_FFFF);
      end
    end
  end

  initial begin
    int cnt;
    reset = 1'b1;
    {exc_break, exc_syscall, exc_overflow, exc_reserved, eret} = '0;
    {mtc0, mfc0, pipe_stall} = '0;
    cp0_sel = '0; wdata = '0; pc_plus_4 = '0; irq = '0;
    step(); step();
    reset = 1'b0;
    mon_en = 1'b1;

    // 1: reset state
    rd(5'd12, 32'h0, "rst_status");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epc");
    rd(5'd7,  32'hFFFF_FFFF, "rst_sel7");
    cp0_sel = 5'd12; #1;
    chk("rdata_no_mfc0", rdata, 32'hFFFF_FFFF);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // 2: syscall, flush exactly 3 cycles
    pc_plus_4 = 32'h100; exc_syscall = 1'b1; exp_q.push_back(32'h0000_F000);
    step();
    exc_syscall = 1'b0;
    chk("sys_epc", epc_q, 32'h100);
    chk("sys_code", {27'd0, cause_q[6:2]}, 32'd8);
    chk("sys_ie", {31'd0, status_q[0]}, 32'd0);
    cnt = 0;
    while (flush && cnt < 10) begin cnt++; step(); end
    chk("sys_flush_len", cnt, 32'd3);
    chk("sys_busy_end", {31'd0, busy}, 32'd0);

    // 3: enable IE + IM[8], raise irq[0]
    pc_plus_4 = 32'h180;
    mtc0 = 1'b1; cp0_sel = 5'd12; wdata = 32'h0000_0101; irq[0] = 1'b1;
    exp_q.push_back(32'h0000_F000);
    step();
    mtc0 = 1'b0;
    for (int i = 0; i < 10 && !redirect_valid; i++) step();
    chk("irq_redir", {31'd0, redirect_valid}, 32'd1);
    chk("irq_code", {27'd0, cause_q[6:2]}, 32'd0);
    chk("irq_ip8", {31'd0, cause_q[8]}, 32'd1);
    chk("irq_epc", epc_q, 32'h180);
    chk("irq_status", status_q, 32'h100);
    irq = '0;
    wait_idle("irq_idle");
    step(); step();
    chk("irq_ip_clr", {31'd0, cause_q[8]}, 32'd0);

    // 4: overflow + syscall + eret together: overflow only
    pc_plus_4 = 32'h200;
    exc_overflow = 1'b1; exc_syscall = 1'b1; eret = 1'b1;
    exp_q.push_back(32'h0000_F000);
    step();
    {exc_overflow, exc_syscall, eret} = '0;
    chk("ov_code", {27'd0, cause_q[6:2]}, 32'd12);
    chk("ov_epc", epc_q, 32'h200);
    chk("ov_status", status_q, 32'h100);
    wait_idle("ov_idle");

    // 5: mtc0 EPC with same-cycle mfc0, then eret; break during flush ignored
    mtc0 = 1'b1; cp0_sel = 5'd14; wdata = 32'h204;
    mfc0 = 1'b1; #1;
    chk("mfc0_prewrite", rdata, 32'h200);
    step();
    mtc0 = 1'b0; mfc0 = 1'b0;
    chk("mtc0_epc", epc_q, 32'h204);
    eret = 1'b1; exp_q.push_back(32'h204);
    step();
    eret = 1'b0; exc_break = 1'b1; pc_plus_4 = 32'h400;
    chk("eret_status", status_q, 32'h101);
    chk("eret_flush", {31'd0, flush}, 32'd1);
    step();
    exc_break = 1'b0;
    wait_idle("eret_idle");
    chk("brk_ignored_code", {27'd0, cause_q[6:2]}, 32'd12);
    chk("brk_ignored_epc", epc_q, 32'h204);

    // 6: reset in 2nd flush cycle
    pc_plus_4 = 32'h300; exc_syscall = 1'b1; exp_q.push_back(32'h0000_F000);
    step();
    exc_syscall = 1'b0;
    step();
    chk("pre_rst_flush", {31'd0, flush}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_flush", {31'd0, flush}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_status", status_q, 32'h0);
    chk("mid_rst_epc", epc_q, 32'h0);

    // mtc0 Cause writes only software IP; unknown sel has no effect
    mtc0 = 1'b1; cp0_sel = 5'd13; wdata = 32'hFFFF_FFFF;
    step();
    chk("cause_swip", cause_q, 32'h300);
    cp0_sel = 5'd7;
    step();
    mtc0 = 1'b0;
    chk("sel7_status", status_q, 32'h0);
    chk("sel7_epc", epc_q, 32'h0);
    chk("sel7_cause", cause_q, 32'h300);

    // stalled exception not taken until stall drops
    pipe_stall = 1'b1; exc_syscall = 1'b1; pc_plus_4 = 32'h500;
    step(); step();
    chk("stall_busy", {31'd0, busy}, 32'd0);
    chk("stall_epc", epc_q, 32'h0);
    pipe_stall = 1'b0; exp_q.push_back(32'h0000_F000);
    step();
    exc_syscall = 1'b0;
    chk("unstall_epc", epc_q, 32'h500);
    wait_idle("unstall_idle");

    step(); step();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
